spi_master: RTL and testbench

Mode-0 SPI master that runs one 8-bit full-duplex frame per `start` request on a single system clock. It generates `sck`, `ss` and `mosi`, samples `miso`, and returns the received byte with a one-cycle `done` pulse. It is the initiating end for the `spi_slave` block and for external SPI peripherals on the Zedboard PMOD headers.

---
 rtl/spi_master.sv | 165 ++++++++++++++++
 tb/tb_spi_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: mode-0 (CPOL=0, CPHA=0) SPI master. Each accepted start request
// runs one 8-bit full-duplex frame: ss falls, 8 sck pulses clock mosi out and
// miso in, then ss rises and the received byte is presented with a done pulse.
//
// Parameters:
//   CLK_DIV   - clk cycles per sck half-period (>= 1)
//   MSB_FIRST - 1: MSB first on both mosi and miso, 0: LSB first
//
// Ports:
//   clk    in   system clock, rising edge
//   rstb   in   synchronous active-low reset
//   start  in   frame request, accepted only while idle
//   tdata  in   [7:0] byte to send, captured on accept
//   miso   in   serial data from slave
//   sck    out  SPI clock, idles low
//   ss     out  slave select, active-low
//   mosi   out  serial data to slave
//   busy   out  frame in progress
//   done   out  one-cycle pulse, rdata valid
//   rdata  out  [7:0] last received byte
module spi_master #(
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       start,
  input  logic [7:0] tdata,
  input  logic       miso,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata
);

  localparam int unsigned DW = $clog2(CLK_DIV + 1);

  typedef enum logic [2:0] {IDLE, LEAD, SCK_LO, SCK_HI, TRAIL} state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_div, w_div;
  logic [3:0]    r_cnt, w_cnt;
  logic [7:0]    r_tx, w_tx, r_rx, w_rx, r_rdata, w_rdata;
  logic          r_sck, w_sck, r_ss, w_ss, r_mosi, w_mosi;
  logic          r_busy, w_busy, r_done, w_done;
  logic          w_div_last;
  logic [7:0]    w_tx_shift;

  assign w_div_last = (r_div == DW'(CLK_DIV - 1));
  // Rotate rather than shift so no tx bit is left dangling; the wrapped bit
  // never reaches mosi within a frame.
  assign w_tx_shift = MSB_FIRST ? {r_tx[6:0], r_tx[7]} : {r_tx[0], r_tx[7:1]};

  // State register
  always_ff @(posedge clk) begin
    if (!rstb) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:   if (start)      w_state_nxt = LEAD;
      LEAD:   if (w_div_last) w_state_nxt = SCK_HI;
      SCK_HI: if (w_div_last) w_state_nxt = (r_cnt == 4'd7) ? TRAIL : SCK_LO;
      SCK_LO: if (w_div_last) w_state_nxt = SCK_HI;
      // TRAIL spans two half-periods: the low half closing the last sck
      // period, then the ss hold. The bit count (8 -> 9) marks the second.
      TRAIL:  if (w_div_last && r_cnt != 4'd8) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / datapath next-value logic (all outputs are registered)
  always_comb begin
    w_sck   = r_sck;
    w_ss    = r_ss;
    w_mosi  = r_mosi;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_rdata = r_rdata;
    w_tx    = r_tx;
    w_rx    = r_rx;
    w_cnt   = r_cnt;
    // Every non-idle transition happens on the last divider cycle, so
    // wrapping there also clears the divider on each state entry.
    w_div   = (r_state == IDLE || w_div_last) ? '0 : r_div + 1'b1;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_tx   = tdata;
          w_ss   = 1'b0;
          w_busy = 1'b1;
          w_mosi = MSB_FIRST ? tdata[7] : tdata[0];
          w_cnt  = '0;
        end
      end
      LEAD, SCK_LO: begin
        if (w_div_last) w_sck = 1'b1;
      end
      SCK_HI: begin
        if (w_div_last) begin
          w_rx  = MSB_FIRST ? {r_rx[6:0], miso} : {miso, r_rx[7:1]};
          w_cnt = r_cnt + 4'd1;
          w_sck = 1'b0;
          if (r_cnt != 4'd7) begin
            w_tx   = w_tx_shift;
            w_mosi = MSB_FIRST ? w_tx_shift[7] : w_tx_shift[0];
          end
        end
      end
      TRAIL: begin
        if (w_div_last) begin
          if (r_cnt == 4'd8) begin
            w_cnt = 4'd9;
          end else begin
            w_ss    = 1'b1;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_mosi  = 1'b0;
            w_rdata = r_rx;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_div   <= '0;
      r_cnt   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_sck   <= 1'b0;
      r_ss    <= 1'b1;
      r_mosi  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_div   <= w_div;
      r_cnt   <= w_cnt;
      r_tx    <= w_tx;
      r_rx    <= w_rx;
      r_sck   <= w_sck;
      r_ss    <= w_ss;
      r_mosi  <= w_mosi;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_rdata <= w_rdata;
    end
  end

  assign sck   = r_sck;
  assign ss    = r_ss;
  assign mosi  = r_mosi;
  assign busy  = r_busy;
  assign done  = r_done;
  assign rdata = r_rdata;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: DUT A (CLK_DIV=4, MSB first) with loopback or a
// mode-0 slave model on miso; DUT B (CLK_DIV=1, LSB first) in loopback.
// Expected done cycle and rdata are queued at launch and checked by monitors.
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0]  r;
    int unsigned c;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  // DUT A
  logic       a_rstb, a_start, a_miso, a_loop;
  logic [7:0] a_tdata;
  logic       a_sck, a_ss, a_mosi, a_busy, a_done;
  logic [7:0] a_rdata;
  // DUT B
  logic       b_rstb, b_start, b_miso;
  logic [7:0] b_tdata;
  logic       b_sck, b_ss, b_mosi, b_busy, b_done;
  logic [7:0] b_rdata;

  // Mode-0 slave model on DUT A
  logic [7:0] s_tx = 8'h00;
  logic [7:0] s_rx = 8'h00;

  assign a_miso = a_loop ? a_mosi : s_tx[7];
  assign b_miso = b_mosi;

  spi_master #(.CLK_DIV(4), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rstb(a_rstb), .start(a_start), .tdata(a_tdata), .miso(a_miso),
    .sck(a_sck), .ss(a_ss), .mosi(a_mosi), .busy(a_busy), .done(a_done),
    .rdata(a_rdata)
  );

  spi_master #(.CLK_DIV(1), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rstb(b_rstb), .start(b_start), .tdata(b_tdata), .miso(b_miso),
    .sck(b_sck), .ss(b_ss), .mosi(b_mosi), .busy(b_busy), .done(b_done),
    .rdata(b_rdata)
  );

  initial begin
    forever begin
      @(negedge a_ss);
      s_tx = 8'h3C;
      while (a_ss === 1'b0) begin
        @(negedge a_sck or posedge a_ss);
        if (a_ss === 1'b0) s_tx = {s_tx[6:0], 1'b0};
      end
    end
  end

  always @(posedge a_sck) s_rx <= {s_rx[6:0], a_mosi};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // mosi capture at each rising sck, and mosi-while-sck-high watch
  logic caps_a[$];
  logic caps_b[$];
  logic a_prev_sck = 1'b0, a_prev_mosi = 1'b0, b_prev_sck = 1'b0;
  int   a_viol = 0;

  always @(negedge clk) begin
    if (a_sck === 1'b1 && a_prev_sck === 1'b0) caps_a.push_back(a_mosi);
    if (a_sck === 1'b1 && a_prev_sck === 1'b1 && a_mosi !== a_prev_mosi) a_viol++;
    if (b_sck === 1'b1 && b_prev_sck === 1'b0) caps_b.push_back(b_mosi);
    a_prev_sck  = a_sck;
    a_prev_mosi = a_mosi;
    b_prev_sck  = b_sck;
  end

  function automatic logic [7:0] pack_a(input int unsigned s);
    logic [7:0] p = '0;
    for (int unsigned i = 0; i < 8; i++) p = {p[6:0], caps_a[s + i]};
    return p;
  endfunction

  function automatic logic [7:0] pack_b(input int unsigned s);
    logic [7:0] p = '0;
    for (int unsigned i = 0; i < 8; i++) p = {p[6:0], caps_b[s + i]};
    return p;
  endfunction

  // Scoreboard monitors
  always @(negedge clk) begin
    if (a_done === 1'b1) begin
      if (sb_a.size() == 0) begin
        chk("a_unexpected_done", 32'(a_done), 32'd0);
      end else begin
        exp_t e;
        e = sb_a.pop_front();
        chk("a_rdata", 32'(a_rdata), 32'(e.r));
        chk("a_done_cycle", cyc, e.c);
        chk("a_done_ss", 32'(a_ss), 32'd1);
        chk("a_done_busy", 32'(a_busy), 32'd0);
      end
    end
    if (b_done === 1'b1) begin
      if (sb_b.size() == 0) begin
        chk("b_unexpected_done", 32'(b_done), 32'd0);
      end else begin
        exp_t e;
        e = sb_b.pop_front();
        chk("b_rdata", 32'(b_rdata), 32'(e.r));
        chk("b_done_cycle", cyc, e.c);
        chk("b_done_ss", 32'(b_ss), 32'd1);
      end
    end
  end

  // Called at a negedge; returns at the following negedge.
  task automatic a_launch(input logic [7:0] d, input logic [7:0] exp_r,
                          input bit expect_done, output int unsigned cs);
    exp_t e;
    cs = caps_a.size();
    a_tdata = d;
    a_start = 1'b1;
    if (expect_done) begin
      e.r = exp_r;
      e.c = cyc + 73;
      sb_a.push_back(e);
    end
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic a_finish(input int unsigned cs, input logic [7:0] exp_mosi, input string nm);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (a_done === 1'b1) seen = 1;
    end
    if (!seen) chk({nm, "_timeout"}, 32'(a_done), 32'd1);
    chk({nm, "_sck_rises"}, caps_a.size() - cs, 32'd8);
    if (caps_a.size() >= cs + 8) chk({nm, "_mosi_bits"}, 32'(pack_a(cs)), 32'(exp_mosi));
  endtask

  initial begin
    int unsigned cs;
    int          v0;
    bit          seen;
    exp_t        eb;

    a_rstb = 1'b0; a_start = 1'b1; a_tdata = 8'hA5; a_loop = 1'b1;
    b_rstb = 1'b0; b_start = 1'b1; b_tdata = 8'h01;

    // Reset with start held high
    repeat (3) begin
      @(negedge clk);
      chk("rst_sck", 32'(a_sck), 32'd0);
      chk("rst_ss", 32'(a_ss), 32'd1);
      chk("rst_mosi", 32'(a_mosi), 32'd0);
      chk("rst_busy", 32'(a_busy), 32'd0);
      chk("rst_done", 32'(a_done), 32'd0);
      chk("rst_rdata", 32'(a_rdata), 32'd0);
      chk("rst_b_ss", 32'(b_ss), 32'd1);
    end
    a_start = 1'b0; b_start = 1'b0;
    a_rstb = 1'b1; b_rstb = 1'b1;
    @(negedge clk);
    chk("rst_no_frame_busy", 32'(a_busy), 32'd0);
    chk("rst_no_frame_ss", 32'(a_ss), 32'd1);

    // Loopback 0xA5
    a_launch(8'hA5, 8'hA5, 1'b1, cs);
    a_finish(cs, 8'hA5, "loop_a5");

    // Slave model: master sends 0xC3, slave answers 0x3C
    repeat (3) @(negedge clk);
    a_loop = 1'b0;
    v0 = a_viol;
    a_launch(8'hC3, 8'h3C, 1'b1, cs);
    a_finish(cs, 8'hC3, "slave");
    chk("slave_rx", 32'(s_rx), 32'hC3);
    chk("slave_mosi_stable", 32'(a_viol), 32'(v0));
    a_loop = 1'b1;

    // Busy-ignore then back-to-back
    repeat (3) @(negedge clk);
    a_launch(8'h5A, 8'h5A, 1'b1, cs);
    repeat (9) @(negedge clk);
    chk("busy_mid", 32'(a_busy), 32'd1);
    a_tdata = 8'hFF;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_finish(cs, 8'h5A, "busy_5a");
    a_launch(8'h96, 8'h96, 1'b1, cs);
    chk("b2b_ss_low", 32'(a_ss), 32'd0);
    a_finish(cs, 8'h96, "b2b_96");

    // Reset during the 4th high phase
    repeat (3) @(negedge clk);
    a_launch(8'h77, 8'h00, 1'b0, cs);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (caps_a.size() >= cs + 4) seen = 1;
    end
    if (!seen) chk("midrst_timeout", caps_a.size() - cs, 32'd4);
    a_rstb = 1'b0;
    @(negedge clk);
    chk("midrst_ss", 32'(a_ss), 32'd1);
    chk("midrst_sck", 32'(a_sck), 32'd0);
    chk("midrst_busy", 32'(a_busy), 32'd0);
    chk("midrst_rdata", 32'(a_rdata), 32'd0);
    a_rstb = 1'b1;
    repeat (100) @(negedge clk);
    chk("midrst_idle", 32'(a_busy), 32'd0);
    a_launch(8'h3C, 8'h3C, 1'b1, cs);
    a_finish(cs, 8'h3C, "after_rst");

    // DUT B: LSB first, CLK_DIV=1, 18-cycle frame
    repeat (2) @(negedge clk);
    cs = caps_b.size();
    b_tdata = 8'h01;
    b_start = 1'b1;
    eb.r = 8'h01;
    eb.c = cyc + 19;
    sb_b.push_back(eb);
    @(negedge clk);
    b_start = 1'b0;
    seen = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (b_done === 1'b1) seen = 1;
    end
    if (!seen) chk("lsb_timeout", 32'(b_done), 32'd1);
    chk("lsb_sck_rises", caps_b.size() - cs, 32'd8);
    if (caps_b.size() >= cs + 8) chk("lsb_mosi_bits", 32'(pack_b(cs)), 32'h80);

    repeat (3) @(negedge clk);
    chk("sb_a_empty", sb_a.size(), 32'd0);
    chk("sb_b_empty", sb_b.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
